// File: rtl/jtgng_ps2_keyev.sv
// PS/2 keyboard front end: conditions the raw PS/2 lines, deframes bytes and
// folds E0/F0/E1 prefixes into a toggle-flagged 11-bit key event word.
module jtgng_ps2_keyev #(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 24000,
   parameter int TW      = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        key_valid,
   output logic        frame_err
);

   localparam int FW = $clog2(FILTER + 1);

   localparam logic [7:0] CODE_E1 = 8'hE1;
   localparam logic [7:0] CODE_E0 = 8'hE0;
   localparam logic [7:0] CODE_F0 = 8'hF0;
   localparam logic [7:0] CODE_AA = 8'hAA;
   localparam logic [7:0] CODE_FA = 8'hFA;
   localparam logic [7:0] CODE_EE = 8'hEE;
   localparam logic [7:0] CODE_FE = 8'hFE;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   logic [1:0]    clk_sync, data_sync;
   logic          filt_clk, filt_clk_d;
   logic [FW-1:0] filt_cnt;
   logic          fe, sdata;

   state_t        state, state_nxt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg, byte_q;
   logic          par_ok;
   logic [TW-1:0] to_cnt;
   logic          byte_rdy, rdy_nxt, err_nxt;

   logic          ext, brk;
   logic [2:0]    skip;

   // Both lines idle high, so the synchronizers and filter reset to 1.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge value of the others, independent of statement order.
      if (rst) begin
         clk_sync   <= 2'b11;
         data_sync  <= 2'b11;
         filt_clk   <= 1'b1;
         filt_clk_d <= 1'b1;
         filt_cnt   <= '0;
      end else begin
         clk_sync   <= {clk_sync[0], ps2_clk};
         data_sync  <= {data_sync[0], ps2_data};
         filt_clk_d <= filt_clk;
         if (clk_sync[1] == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER - 1)) begin
            filt_clk <= clk_sync[1];
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   assign fe    = filt_clk_d & ~filt_clk;
   assign sdata = data_sync[1];

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave a value unassigned and infer a latch.
      state_nxt = state;
      err_nxt   = 1'b0;
      rdy_nxt   = 1'b0;
      if (fe) begin
         case (state)
            ST_IDLE: begin
               if (!sdata) state_nxt = ST_DATA;
               else        err_nxt   = 1'b1;
            end
            ST_DATA: begin
               if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
            end
            ST_PARITY: state_nxt = ST_STOP;
            default: begin
               if (sdata && par_ok) rdy_nxt = 1'b1;
               else                 err_nxt = 1'b1;
               state_nxt = ST_IDLE;
            end
         endcase
      end else if (state != ST_IDLE && to_cnt == TW'(TIMEOUT - 1)) begin
         state_nxt = ST_IDLE;
         err_nxt   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         byte_q    <= '0;
         par_ok    <= 1'b0;
         to_cnt    <= '0;
         byte_rdy  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         byte_rdy  <= rdy_nxt;
         frame_err <= err_nxt;
         if (rdy_nxt) byte_q <= shreg;
         to_cnt <= (fe || state == ST_IDLE) ? '0 : to_cnt + TW'(1);
         if (fe) begin
            case (state)
               ST_IDLE:   bit_cnt <= '0;
               ST_DATA: begin
                  shreg   <= {sdata, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
               ST_PARITY: par_ok <= ^{sdata, shreg};
               default:   ;
            endcase
         end
      end
   end

   // Only accepted bytes reach here, so rejected frames never touch the flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         ps2_key   <= '0;
         key_valid <= 1'b0;
         ext       <= 1'b0;
         brk       <= 1'b0;
         skip      <= '0;
      end else begin
         key_valid <= 1'b0;
         if (byte_rdy) begin
            if (skip != 3'd0) begin
               skip <= skip - 3'd1;
            end else begin
               case (byte_q)
                  CODE_E1: begin
                     skip <= 3'd7;
                     ext  <= 1'b0;
                     brk  <= 1'b0;
                  end
                  CODE_E0: ext <= 1'b1;
                  CODE_F0: brk <= 1'b1;
                  CODE_AA, CODE_FA, CODE_EE, CODE_FE: begin
                     ext <= 1'b0;
                     brk <= 1'b0;
                  end
                  default: begin
                     ps2_key   <= {~ps2_key[10], ~brk, ext, byte_q};
                     key_valid <= 1'b1;
                     ext       <= 1'b0;
                     brk       <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: doc/jtgng_ps2_keyev.md
Name: jtgng_ps2_keyev

Overview:
- PS/2 keyboard front end. It turns the raw PS/2 clock/data lines into the 11-bit toggle-flagged key event word that the core keyboard decoders consume.
- Word format:
  - bit 10: toggle. It flips on every new event.
  - bit 9: pressed.
  - bit 8: extended (E0 prefix).
  - bits 7:0: scancode.
- It runs in the game clock domain. Consumers detect a new event by comparing bit 10 against its previous value.

Parameters:
- FILTER, 8, number of consecutive identical samples needed before the filtered ps2_clk level changes.
- TIMEOUT, 24000, idle cycles after which a partial frame is discarded (1 ms at 24 MHz).
- TW, 15, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- ps2_key  out  11  event word {toggle, pressed, extended, code[7:0]}.
- key_valid  out  1  one-cycle pulse, high in the same cycle that ps2_key changes.
- frame_err  out  1  one-cycle pulse on a parity, start, stop or timeout error.

Behaviour:
- Reset (rst high at a clk edge):
  - ps2_key = 0, key_valid = 0, frame_err = 0.
  - Frame FSM goes to IDLE; E0/F0 flags and the E1 skip counter are cleared.
  - Reset has priority over every other event, including mid-frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - Filtered clock changes level only after FILTER identical consecutive samples.
  - A falling edge of the filtered clock produces a 1-cycle strobe `fe`.
  - ps2_data (synchronized) is sampled on `fe`.
- Frame FSM (advances only on `fe`):
  - IDLE: data=0 → DATA with bit count 0. data=1 → stay in IDLE and pulse frame_err.
  - DATA: shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: compute odd parity over the 8 data bits plus the parity bit. Store ok/bad → STOP.
  - STOP: if data=1 and parity ok → hand the byte to the decoder (strobe `byte_rdy` in the next cycle). Otherwise pulse frame_err. Either way → IDLE.
- Timeout:
  - Counter clears on every `fe` and in IDLE.
  - In a non-IDLE state, when it reaches TIMEOUT-1 → IDLE, pulse frame_err, no byte emitted.
  - Partial bits are discarded. Prefix flags are kept.
- Byte decoder (acts on `byte_rdy`):
  - E1 skip counter nonzero: decrement it, no event (covers the Pause sequence).
  - 0xE1: load skip counter = 7, clear flags, no event.
  - 0xE0: set ext flag, no event.
  - 0xF0: set brk flag, no event.
  - 0xAA, 0xFA, 0xEE, 0xFE: clear both flags, no event.
  - Any other code: ps2_key <= {~ps2_key[10], ~brk, ext, code}. Pulse key_valid, clear both flags.
- Latency:
  - The `fe` that samples the stop bit is cycle N.
  - ps2_key changes and key_valid is high at cycle N+2.
- Simultaneous events: `fe` and timeout expiry in the same cycle → `fe` wins and the counter clears.
- Error pulses:
  - frame_err and key_valid are never both high in one cycle.
  - A rejected byte never changes the prefix flags.
- Output hold: ps2_key holds its value between events. Toggle wraps naturally, 1 → 0.

Test Plan:
- Reset, then frame for 0x1C (data 0011_1000 LSB first, parity 0, stop 1) at 10 kHz → key_valid once, ps2_key = 11'h61C.
- Then F0,1C → one event, ps2_key = 11'h01C (toggle 0, released); no event on the F0 byte.
- E0,75 then E0,F0,75 → ps2_key = 11'h775, then 11'h175.
- 0x29 sent with a flipped parity bit → frame_err pulse, no key_valid, ps2_key unchanged. A following valid 0x29 produces 11'h629 relative to the prior toggle.
- Frame aborted after 4 data bits, line idle > TIMEOUT cycles → exactly one frame_err, FSM in IDLE. Next full 0x05 frame decodes correctly.
- Pause sequence E1,14,77,E1,F0,14,F0,77 → no key_valid. A subsequent 0x06 emits code 06 with ext=0, pressed=1.
- rst asserted mid-frame (after bit 5) → ps2_key = 0 next cycle. The remaining bits of that frame produce no event (start bit mismatch or timeout only).
- Glitch on ps2_clk shorter than FILTER samples → no bit shifted, no error.
